// File: rtl/score_level_grader.sv
// Song score accumulator with a sequential grader: sums per-note timing errors,
// then compares the frozen score against an ascending threshold table, one entry per cycle.
module score_level_grader #(
    parameter int SCORE_W = 32,
    parameter int ERR_W   = 16,
    parameter int N_THRESH = 3,
    parameter logic [N_THRESH*SCORE_W-1:0] THRESHOLDS =
        {32'd1000000000, 32'd700000000, 32'd100000000},
    parameter int CODE_W = 5,
    parameter logic [(N_THRESH+1)*4*CODE_W-1:0] LEVEL_CODES = '0,
    parameter logic [CODE_W-1:0] BLANK_CODE = '0,
    localparam int LVL_W = $clog2(N_THRESH+1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    input  logic               err_valid_i,
    input  logic [ERR_W-1:0]   err_i,
    input  logic               finish_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [SCORE_W-1:0] score_o,
    output logic               saturated_o,
    output logic [LVL_W-1:0]   level_o,
    output logic [CODE_W-1:0]  p0_o,
    output logic [CODE_W-1:0]  p1_o,
    output logic [CODE_W-1:0]  p2_o,
    output logic [CODE_W-1:0]  p3_o
);

    localparam int IDX_W = (N_THRESH > 1) ? $clog2(N_THRESH) : 1;
    // One spare bit above the wider operand so the carry out is never lost.
    localparam int SUM_W = ((ERR_W > SCORE_W) ? ERR_W : SCORE_W) + 1;
    localparam logic [SUM_W-1:0] SUM_MAX = {{(SUM_W-SCORE_W){1'b0}}, {SCORE_W{1'b1}}};

    typedef enum logic [1:0] {S_RUN, S_GRADE, S_HOLD} state_t;

    state_t              state_q;
    logic [SCORE_W-1:0]  score_q;
    logic                sat_q;
    logic [LVL_W-1:0]    level_q;
    logic [IDX_W-1:0]    idx_q;
    logic                busy_q;
    logic                done_q;
    logic [4*CODE_W-1:0] digits_q;

    logic [SCORE_W-1:0]  thr [N_THRESH];
    logic [4*CODE_W-1:0] codes [N_THRESH+1];

    genvar gi;
    generate
        for (gi = 0; gi < N_THRESH; gi++) begin : g_thr
            assign thr[gi] = THRESHOLDS[gi*SCORE_W +: SCORE_W];
        end
        for (gi = 0; gi < N_THRESH+1; gi++) begin : g_codes
            assign codes[gi] = LEVEL_CODES[gi*4*CODE_W +: 4*CODE_W];
        end
    endgenerate

    logic [SUM_W-1:0]    sum_d;
    logic                clip_d;
    logic [SCORE_W-1:0]  acc_d;
    logic [SCORE_W-1:0]  thr_sel_d;
    logic [LVL_W-1:0]    level_d;
    logic [4*CODE_W-1:0] code_sel_d;
    logic                last_d;

    always_comb begin
        sum_d  = SUM_W'(score_q) + SUM_W'(err_i);
        clip_d = sum_d > SUM_MAX;
        acc_d  = clip_d ? {SCORE_W{1'b1}} : sum_d[SCORE_W-1:0];

        thr_sel_d = '0;
        for (int k = 0; k < N_THRESH; k++) begin
            if (idx_q == IDX_W'(k)) thr_sel_d = thr[k];
        end
        level_d = level_q + LVL_W'(score_q > thr_sel_d);
        last_d  = (idx_q == IDX_W'(N_THRESH-1));

        // Digits latched on the last compare must use the level including that compare.
        code_sel_d = '0;
        for (int k = 0; k < N_THRESH+1; k++) begin
            if (level_d == LVL_W'(k)) code_sel_d = codes[k];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_RUN;
            score_q  <= '0;
            sat_q    <= 1'b0;
            level_q  <= '0;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            digits_q <= {4{BLANK_CODE}};
        end else if (clear_i) begin
            state_q  <= S_RUN;
            score_q  <= '0;
            sat_q    <= 1'b0;
            level_q  <= '0;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            digits_q <= {4{BLANK_CODE}};
        end else begin
            case (state_q)
                S_RUN: begin
                    if (err_valid_i) begin
                        score_q <= acc_d;
                        if (clip_d) sat_q <= 1'b1;
                    end
                    if (finish_i) begin
                        state_q <= S_GRADE;
                        level_q <= '0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_GRADE: begin
                    level_q <= level_d;
                    idx_q   <= idx_q + IDX_W'(1);
                    if (last_d) begin
                        state_q  <= S_HOLD;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        digits_q <= code_sel_d;
                    end
                end
                S_HOLD: begin
                    done_q <= 1'b0;
                end
                default: begin
                    state_q <= S_RUN;
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign score_o     = score_q;
    assign saturated_o = sat_q;
    assign level_o     = level_q;
    assign p0_o        = digits_q[0*CODE_W +: CODE_W];
    assign p1_o        = digits_q[1*CODE_W +: CODE_W];
    assign p2_o        = digits_q[2*CODE_W +: CODE_W];
    assign p3_o        = digits_q[3*CODE_W +: CODE_W];

endmodule

// File: doc/score_level_grader.md
Name: score_level_grader

Overview:
- Sequential, parametrised successor to the combinational score-to-level converter.
- Accumulates per-note timing-error magnitudes into a saturating score during a song.
- On song end, grades the frozen score against a parametrised, ascending threshold table, one compare per cycle.
- Holds the resulting level index and its 7-seg digit codes for the display mux until cleared.

Parameters:
- SCORE_W, 32: score accumulator width.
- ERR_W, 16: width of one error sample.
- N_THRESH, 3: number of thresholds. Levels run 0..N_THRESH.
- THRESHOLDS, {32'd1000000000, 32'd700000000, 32'd100000000}: packed N_THRESH*SCORE_W. Element i is bits [i*SCORE_W +: SCORE_W] and must be strictly ascending in i.
- CODE_W, 5: width of one display digit code.
- LEVEL_CODES, all zero: packed (N_THRESH+1)*4*CODE_W. Entry L is {p3,p2,p1,p0} for level L.
- BLANK_CODE, 5'd0: digit code driven on all digits when no grade is held.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- clear  in  1  synchronous restart. Returns to RUN with score 0.
- err_valid  in  1  err qualifier, one sample per asserted cycle
- err  in  ERR_W  error magnitude, zero-extended into the score
- finish  in  1  end-of-song strobe
- busy  out  1  high while in GRADE
- done  out  1  one-cycle pulse when the grade becomes valid
- score  out  SCORE_W  current or frozen accumulated score
- saturated  out  1  sticky: the accumulator clipped at all-ones
- level  out  clog2(N_THRESH+1)  graded level, 0 = best
- p0, p1, p2, p3  out  CODE_W  display digit codes

Behaviour:
- Reset: all outputs are asynchronously cleared to 0, except p0..p3, which go to BLANK_CODE. State is RUN.
- States: RUN, GRADE, HOLD.
- Priority each cycle: rst > clear > state logic. clear in any state gives next state RUN with score=0, saturated=0, level=0, digits=BLANK_CODE, done=0.
- RUN:
  - If err_valid, score <= min(score + err, 2^SCORE_W - 1), with the add done at SCORE_W+1 bits. saturated is set if the clip occurs.
  - If finish, go to GRADE. If err_valid and finish arrive in the same cycle, that sample is accumulated and included in the grade.
- GRADE:
  - Index counter i runs 0..N_THRESH-1, one compare per cycle.
  - level increments when score > THRESHOLDS[i]. The compare is strict; equality does not increment.
  - level is cleared on entry to GRADE.
  - After N_THRESH cycles, go to HOLD.
  - err_valid and finish are ignored. Digits stay BLANK_CODE. busy=1.
- HOLD:
  - On entry: done=1 for exactly one cycle, and p3..p0 <= LEVEL_CODES entry [level].
  - Outputs then hold until clear or rst. err_valid and finish are ignored.
- Latency: finish sampled at edge t gives done high in the cycle after edge t+N_THRESH, i.e. N_THRESH+1 cycles after the finish cycle.
- Final level equals the count of thresholds strictly exceeded. With the defaults:
  - level 0: score ≤ 100M
  - level 1: score in (100M, 700M]
  - level 2: score in (700M, 1000M]
  - level 3: score > 1000M
- rst asserted mid-GRADE aborts immediately. No done pulse is issued.
- finish held high for several cycles grades once. A new grade requires clear then finish.

Test Plan:
- Reset: rst pulsed mid-RUN, then released → score=0, level=0, done=0, busy=0, digits=BLANK_CODE. An err_valid sample of 5 then gives score=5.
- Boundary grading: accumulate exactly 100000000, then finish → busy for 3 cycles, done on cycle 4, level=0. Repeat with 100000001 → level=1. Repeat with 1000000001 → level=3, and p3..p0 equal LEVEL_CODES entry 3.
- Simultaneous events: score 699999999, then err_valid (err=1) together with finish → graded score 700000000, level=1. err_valid pulses during GRADE and HOLD leave score unchanged.
- Saturation: preload to all-ones minus 2 via samples, then err=16'hFFFF → score=32'hFFFFFFFF, saturated=1. finish then gives level=3.
- Clear/abort: clear during the 2nd GRADE cycle → RUN, score=0, no done pulse. rst during GRADE → same outcome. Then clear in HOLD → digits=BLANK_CODE, saturated=0.
- Parametrisation: N_THRESH=1, THRESHOLDS=10, SCORE_W=8 → done 2 cycles after finish. Score 10 gives level 0, 11 gives level 1, and saturation occurs at 255.
